// File: rtl/modred_issuer.sv
// modred_issuer: buffers operands, issues one modular reduction job at a
// time to a serial reducer via start/valid, and returns x mod m on a stream.
//
// Ports:
//   clk_i, rst_ni       clock (rising edge), async active-low reset
//   m_i                 modulus, sampled per job when the operand is popped
//   in_valid_i/in_x_i   operand stream; in_ready_o = FIFO not full
//   red_start_o         one-cycle start pulse to the reducer
//   red_x_o/red_m_o     operand and modulus of the current job
//   red_m_bl_o          ceil(log2(m)) of the current job
//   red_valid_i         reducer done level; red_result_i its result
//   out_valid_o         result valid, held until out_ready_i
//   out_result_o        x mod m, or 0 when out_err_o (timeout)
//   out_x_o             echo of the job's x
//   busy_o              job in flight or operands queued
//   job_cnt_o           completed jobs, including aborted ones
module modred_issuer #(
    parameter int unsigned WIDTH          = 64,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] m_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_x_i,
    output logic             in_ready_o,
    output logic             red_start_o,
    output logic [WIDTH-1:0] red_x_o,
    output logic [WIDTH-1:0] red_m_o,
    output logic [WIDTH-1:0] red_m_bl_o,
    input  logic             red_valid_i,
    input  logic [WIDTH-1:0] red_result_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_result_o,
    output logic [WIDTH-1:0] out_x_o,
    output logic             out_err_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic [15:0]      job_cnt_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] WCNT_ONE = CW'(1);
    localparam logic [CW-1:0] WCNT_END = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUT
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Operand FIFO
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    assign in_ready_o = (count != CNT_FULL);
    assign push       = in_valid_i && in_ready_o;
    assign pop        = (state == S_IDLE) && (count != '0);
    assign busy_o     = (state != S_IDLE) || (count != '0);

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= in_x_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bit length: smallest k with 2^k >= m, i.e. one past the leading
    // one of (m - 1). m of 0 or 1 yields 0.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] m_dec;
    logic [WIDTH-1:0] m_bl_c;

    always_comb begin
        m_dec  = m_i - WIDTH'(1);
        m_bl_c = '0;
        if (m_i > WIDTH'(1)) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (m_dec[i]) begin
                    m_bl_c = WIDTH'(i + 1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Job sequencer
    // ------------------------------------------------------------------
    logic [CW-1:0] wcnt;
    logic          prev_valid;
    logic          done;

    // Only a rising edge counts: the reducer may still hold valid high
    // from the previous job when the next one starts.
    assign done = red_valid_i && !prev_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            red_start_o  <= 1'b0;
            red_x_o      <= '0;
            red_m_o      <= '0;
            red_m_bl_o   <= '0;
            out_valid_o  <= 1'b0;
            out_result_o <= '0;
            out_x_o      <= '0;
            out_err_o    <= 1'b0;
            job_cnt_o    <= '0;
            wcnt         <= '0;
            prev_valid   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        red_x_o     <= mem[rd_ptr];
                        red_m_o     <= m_i;
                        red_m_bl_o  <= m_bl_c;
                        red_start_o <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    red_start_o <= 1'b0;
                    wcnt        <= '0;
                    prev_valid  <= red_valid_i;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    prev_valid <= red_valid_i;
                    // done takes priority over an expiring timeout
                    if (done) begin
                        out_result_o <= red_result_i;
                        out_x_o      <= red_x_o;
                        out_err_o    <= 1'b0;
                        out_valid_o  <= 1'b1;
                        state        <= S_OUT;
                    end else if (wcnt == WCNT_END) begin
                        out_result_o <= '0;
                        out_x_o      <= red_x_o;
                        out_err_o    <= 1'b1;
                        out_valid_o  <= 1'b1;
                        state        <= S_OUT;
                    end else begin
                        wcnt <= wcnt + WCNT_ONE;
                    end
                end
                S_OUT: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        job_cnt_o   <= job_cnt_o + 16'd1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modred_issuer.sv
// tb_modred_issuer: directed self-checking bench for modred_issuer with a
// behavioural reducer model and an expected-result scoreboard queue.
module tb_modred_issuer;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int TO = 64;
    localparam int L  = 5;
    localparam logic [W-1:0] M7 = 32'h7FFF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  m_in = '0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_x = '0;
    logic          in_ready;
    logic          red_start;
    logic [W-1:0]  red_x;
    logic [W-1:0]  red_m;
    logic [W-1:0]  red_m_bl;
    logic          red_valid;
    logic [W-1:0]  red_result;
    logic          out_valid;
    logic [W-1:0]  out_result;
    logic [W-1:0]  out_x;
    logic          out_err;
    logic          out_ready = 1'b0;
    logic          busy;
    logic [15:0]   job_cnt;

    always #5 clk = ~clk;

    modred_issuer #(
        .WIDTH(W),
        .FIFO_DEPTH(D),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .m_i(m_in),
        .in_valid_i(in_valid),
        .in_x_i(in_x),
        .in_ready_o(in_ready),
        .red_start_o(red_start),
        .red_x_o(red_x),
        .red_m_o(red_m),
        .red_m_bl_o(red_m_bl),
        .red_valid_i(red_valid),
        .red_result_i(red_result),
        .out_valid_o(out_valid),
        .out_result_o(out_result),
        .out_x_o(out_x),
        .out_err_o(out_err),
        .out_ready_i(out_ready),
        .busy_o(busy),
        .job_cnt_o(job_cnt)
    );

    // Reducer model: answers L cycles after start unless stalled.
    logic         model_valid = 1'b0;
    logic [W-1:0] model_res = '0;
    logic [W-1:0] mx = '0;
    logic [W-1:0] mm = '0;
    int           mcnt = 0;
    bit           pending = 1'b0;
    bit           stall = 1'b0;
    bit           force_high = 1'b0;

    always @(posedge clk) begin
        if (red_start) begin
            model_valid <= 1'b0;
            pending     <= 1'b1;
            mcnt        <= L - 1;
            mx          <= red_x;
            mm          <= red_m;
        end else if (pending && !stall) begin
            if (mcnt == 0) begin
                model_valid <= 1'b1;
                model_res   <= (mm == '0) ? mx : mx % mm;
                pending     <= 1'b0;
            end else begin
                mcnt <= mcnt - 1;
            end
        end
    end

    assign red_valid  = model_valid | force_high;
    assign red_result = model_res;

    int cyc = 0;
    int starts = 0;
    int start_cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (red_start) begin
            starts    <= starts + 1;
            start_cyc <= cyc + 1;
        end
    end

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] res;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_jobs = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] x, input logic [W-1:0] m,
                        input logic err);
        exp_t e;
        int   k;
        k = 0;
        in_x = x;
        in_valid = 1'b1;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("push_ready", in_ready, 1);
        @(posedge clk);
        e.x = x;
        e.res = err ? '0 : x % m;
        e.err = err;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int k;
        k = 0;
        while (!out_valid && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("out_valid", out_valid, 1);
    endtask

    task automatic collect();
        exp_t e;
        wait_out();
        check("sb_nonempty", sb.size() != 0, 1);
        e = '0;
        if (sb.size() != 0) e = sb.pop_front();
        check("out_result", out_result, e.res);
        check("out_x", out_x, e.x);
        check("out_err", out_err, e.err);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        exp_jobs++;
        check("out_valid_drop", out_valid, 0);
        check("job_cnt", job_cnt, exp_jobs);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] xs [6];
    int n_acc;

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_start", red_start, 0);
        check("rst_busy", busy, 0);
        check("rst_job_cnt", job_cnt, 0);
        check("rst_m_bl", red_m_bl, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single job, m = 2^31-1
        m_in = M7;
        push(32'h1, M7, 1'b0);
        wait_out();
        check("m_bl_7fff", red_m_bl, 31);
        check("one_start", starts, 1);
        collect();

        // back-to-back jobs, output held off for 10 cycles
        push(32'h8000_0005, M7, 1'b0);
        push(32'hFFFF_FFFF, M7, 1'b0);
        wait_out();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_result", out_result, 32'h6);
        end
        check("hold_no_start", starts, 2);
        collect();
        collect();
        check("btb_res_model", 32'hFFFF_FFFF % M7, 1);

        // m = 2^31, m_i changed while job in flight
        m_in = 32'h8000_0000;
        push(32'h8000_0003, 32'h8000_0000, 1'b0);
        repeat (2) @(negedge clk);
        m_in = 32'h0001_2345;
        wait_out();
        check("m_bl_8000", red_m_bl, 31);
        check("m_held", red_m, 32'h8000_0000);
        collect();

        // FIFO fill with stalled reducer
        m_in = M7;
        xs[0] = 32'd10;
        xs[1] = 32'h7FFF_FFFF;
        xs[2] = 32'h7FFF_FFFE;
        xs[3] = 32'hFFFF_FFFE;
        xs[4] = 32'hDEAD_BEEF;
        xs[5] = 32'h1234_5678;
        stall = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_x = xs[i];
            in_valid = 1'b1;
            if (!in_ready) break;
            @(posedge clk);
            sb.push_back('{x: xs[i], res: xs[i] % M7, err: 1'b0});
            n_acc++;
            @(negedge clk);
        end
        check("fifo_accepted", n_acc, 5);
        check("fifo_full", in_ready, 0);
        in_valid = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 5; i++) collect();

        // timeout, then held-high valid must not complete next job
        stall = 1'b1;
        push(32'h55, M7, 1'b1);
        wait_out();
        check("timeout_lat", cyc - start_cyc, TO);
        collect();
        force_high = 1'b1;
        push(32'h66, M7, 1'b1);
        collect();
        force_high = 1'b0;

        // reset mid-job drops job and queued operand
        push(32'h77, M7, 1'b0);
        push(32'h88, M7, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_start", red_start, 0);
        check("mid_rst_red_x", red_x, 0);
        check("mid_rst_m_bl", red_m_bl, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_job_cnt", job_cnt, 0);
        check("mid_rst_err", out_err, 0);
        sb.delete();
        exp_jobs = 0;
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", busy, 0);
        push(32'h7, M7, 1'b0);
        collect();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
